uart_rx_os: RTL
===============

// Module: uart_rx_os
// PURPOSE
//  Parametrised oversampling UART receiver: self-contained FSM + datapath.
//  Configurable data width, parity and stop bits; 3-sample majority vote; start-glitch rejection.
//  Reports framing/parity/overrun/break conditions; ready/valid output toward the RX FIFO or host.
// PARAMETERS
//  CLK_FREQ    100_000_000  system clock frequency, Hz
//  BAUD_RATE   115200       line rate, bit/s
//  OVERSAMPLE  16           sample ticks per bit; legal values >= 8
//  DATA_WIDTH  8            data bits per frame; legal range 5..9
//  PARITY      0            0 = none, 1 = even, 2 = odd
//  STOP_BITS   1            1 or 2
// PORTS
//  clock       in   1           system clock; all logic on posedge
//  reset_n     in   1           synchronous reset, active low
//  rx_in       in   1           asynchronous serial line, idles high
//  data_out    out  DATA_WIDTH  received word, LSB = first bit on the line
//  data_valid  out  1           holding register full
//  data_ready  in   1           consumer accepts when data_valid && data_ready
//  frame_err   out  1           stop bit sampled 0; qualified by data_valid
//  parity_err  out  1           parity mismatch; qualified by data_valid; 0 when PARITY = 0
//  break_det   out  1           all data, parity and stop samples 0; qualified by data_valid
//  overrun     out  1           1-cycle pulse: frame completed while the holding register was full
//  busy        out  1           FSM not in IDLE
// BEHAVIOUR
//  - Reset (reset_n = 0 at posedge): FSM -> IDLE; all counters = 0; data_out = 0;
//    data_valid, all error flags, overrun, busy = 0; synchroniser flops = 1.
//    Mid-frame reset abandons the frame with no output.
//  - rx_in passes through a 2-flop synchroniser; rx_s is the synchronised line.
//  - Tick counter: free-running 0..CLKS_PER_SAMPLE-1 with CLKS_PER_SAMPLE = CLK_FREQ/(BAUD_RATE*OVERSAMPLE).
//    tick = (count == CLKS_PER_SAMPLE-1); wraps to 0.
//  - sample_count counts 0..OVERSAMPLE-1 on ticks and is cleared when entering START.
//    On each tick a 3-bit history shifts in rx_s; vote = majority of the history.
//  - Vote point: sample_count == OVERSAMPLE/2+1 (window OS/2-1..OS/2+1).
//    End of bit: sample_count == OVERSAMPLE-1 with tick.
//  - FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
//    IDLE:      rx_s == 0 -> START.
//    START:     at vote point, vote = 1 -> IDLE (glitch, no flags); else at end of bit -> DATA.
//    DATA:      at vote point shift the vote in at the MSB, shift right.
//               bit_count runs 0..DATA_WIDTH-1; the end of the last bit -> PARITY if PARITY != 0, else STOP.
//    PARITY:    at vote point latch par_err = (^data ^ vote) != (PARITY == 2); end of bit -> STOP.
//    STOP:      at the vote point of each stop bit, vote = 0 sets ferr.
//               Deliver at the vote point of the final stop bit (half-bit early, for resync).
//               Then -> WAIT_HIGH if break, else -> IDLE.
//    WAIT_HIGH: stay until rx_s == 1, then -> IDLE.
//  - Delivery occurs on the clock after the final stop vote tick:
//    - if !data_valid or (data_valid && data_ready) in that cycle, load data_out and the flags and set data_valid = 1;
//    - else hold the old word and flags and pulse overrun for 1 cycle; the new frame is dropped.
//  - data_valid clears on the posedge where data_valid && data_ready, unless a delivery loads in the same cycle.
//  - data_out and flags are stable while data_valid = 1.
// STRUCTURE
//  - uart_pkg (shared): rx_state_t enum; parity_mode_t {PAR_NONE, PAR_EVEN, PAR_ODD};
//    function clks_per_sample(clk, baud, os).
//  - One sub-module: uart_baud_tick #(CLK_FREQ, BAUD_RATE, OVERSAMPLE) (clock, reset_n, tick).
//    This is the same generator the TX side uses.
//  - Counters and the shift register use the existing Counter / ShiftRegisterSIPO blocks where the widths fit.
// TESTING
//  1. Defaults (54 clk/sample, 864 clk/bit), send 0xA5 8N1 with data_ready = 1.
//     -> data_out = 0xA5, no flags, data_valid high 1 clk, busy low after the mid-stop vote.
//  2. Low glitch of 200 clk on an idle line.
//     -> back to IDLE, no data_valid, no flags.
//  3. PARITY = 1, send 0x37 with a wrong parity bit.
//     -> data_out = 0x37, parity_err = 1; correct parity -> parity_err = 0.
//  4. Hold data_ready = 0, send 0x11 then 0x22.
//     -> data_out stays 0x11, overrun pulses once.
//     Then assert data_ready on the exact delivery cycle of a third frame 0x33 -> 0x33 loads, no overrun.
//  5. Line low for 12 bit times then high.
//     -> data_out = 0x00, frame_err = 1, break_det = 1.
//     The FSM waits in WAIT_HIGH; the next frame 0x5A decodes cleanly.
//  6. reset_n low for 1 clk in the middle of DATA bit 3.
//     -> all outputs at reset values; the following 0xC3 frame is received correctly.
//  Also: DATA_WIDTH = 5, STOP_BITS = 2 with a mid-stop jitter of +/-3 samples; each frame decodes without flags.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter types and baud helper
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_mode_t;

    function automatic int clks_per_sample(input int clk, input int baud, input int os);
        return clk / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick generator shared by RX and TX
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);

    localparam int CPS = clks_per_sample(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = (CPS > 1) ? $clog2(CPS) : 1;

    logic [CW-1:0] count_q;

    assign tick = (count_q == CW'(CPS - 1));

    // Count clocks per sample and wrap on the tick
    always_ff @(posedge clock) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= tick ? '0 : count_q + 1'b1;
    end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority vote, error flags and ready/valid output
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  break_det,
    output logic                  overrun,
    output logic                  busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam parity_mode_t PMODE = parity_mode_t'(PARITY);
    localparam logic [SW-1:0] VOTE_AT = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] LAST_S  = SW'(OVERSAMPLE - 1);

    rx_state_t state_q, state_d;
    logic tick, rx_s, vote, vote_pt, bit_end, start_clr;
    logic [1:0] sync_q, hist_q;
    logic [SW-1:0] sample_q;
    logic [BW-1:0] bit_q, bit_d;
    logic stop_q, stop_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q;
    logic ferr_q, ferr_d, perr_q, perr_d, zero_q, zero_d, pend_q, pend_d;
    logic valid_q, fe_q, pe_q, bk_q, ovr_q;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clock  (clock),
        .reset_n(reset_n),
        .tick   (tick)
    );

    // Vote over the two previous samples plus the current one
    assign rx_s    = sync_q[1];
    assign vote    = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
    assign vote_pt = tick && (sample_q == VOTE_AT);
    assign bit_end = tick && (sample_q == LAST_S);

    // Synchronise the line, count samples within a bit, keep the vote history
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q   <= 2'b11;
            hist_q   <= 2'b11;
            sample_q <= '0;
        end else begin
            sync_q <= {sync_q[0], rx_in};
            if (tick) hist_q <= {hist_q[0], rx_s};
            if (start_clr) sample_q <= '0;
            else if (tick) sample_q <= bit_end ? '0 : sample_q + 1'b1;
        end
    end

    // Frame FSM: next state and frame-assembly updates
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        ferr_d    = ferr_q;
        perr_d    = perr_q;
        zero_d    = zero_q;
        pend_d    = 1'b0;
        start_clr = 1'b0;
        case (state_q)
            S_IDLE: if (!rx_s) begin
                state_d   = S_START;
                start_clr = 1'b1;
                bit_d     = '0;
                stop_d    = 1'b0;
                ferr_d    = 1'b0;
                perr_d    = 1'b0;
                zero_d    = 1'b1;
            end
            S_START: begin
                if (vote_pt && vote) state_d = S_IDLE;
                else if (bit_end)    state_d = S_DATA;
            end
            S_DATA: begin
                if (vote_pt) begin
                    shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
                    if (vote) zero_d = 1'b0;
                end
                if (bit_end) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BW'(DATA_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = (PMODE != PAR_NONE) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (vote_pt) begin
                    perr_d = ((^shift_q) ^ vote) != (PMODE == PAR_ODD);
                    if (vote) zero_d = 1'b0;
                end
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (vote_pt) begin
                    if (!vote) ferr_d = 1'b1;
                    else       zero_d = 1'b0;
                    if (stop_q == 1'(STOP_BITS - 1)) begin
                        pend_d  = 1'b1;
                        state_d = (zero_q && !vote) ? S_WAIT_HIGH : S_IDLE;
                    end
                end else if (bit_end) stop_d = 1'b1;
            end
            S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and frame-assembly registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            zero_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            zero_q  <= zero_d;
            pend_q  <= pend_d;
        end
    end

    // Holding register: load a finished frame if free or draining, otherwise drop it and flag overrun
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            bk_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= pend_q && valid_q && !data_ready;
            if (pend_q && (!valid_q || data_ready)) begin
                data_q  <= shift_q;
                fe_q    <= ferr_q;
                pe_q    <= perr_q;
                bk_q    <= zero_q;
                valid_q <= 1'b1;
            end else if (data_ready) valid_q <= 1'b0;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign break_det  = bk_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);

endmodule
